// File: rtl/vga_pkg.sv
// Shared 640x480 VGA timing constants and the RGB888 pixel type used by the
// scan-out path and its line buffer.
package vga_pkg;

    localparam int unsigned SCREEN_W = 640;
    localparam int unsigned H_FP     = 16;
    localparam int unsigned H_SYNC   = 96;
    localparam int unsigned H_BP     = 48;
    localparam int unsigned H_TOTAL  = SCREEN_W + H_FP + H_SYNC + H_BP;

    localparam int unsigned V_ACTIVE = 480;
    localparam int unsigned V_FP     = 10;
    localparam int unsigned V_SYNC   = 2;
    localparam int unsigned V_BP     = 33;
    localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } pixel_t;

endpackage

// File: rtl/vga_scanout_line_ram.sv
// Ping-pong line buffer: two banks of DEPTH pixels addressed {bank, x}, one
// write port and one registered read port that returns black in blanking.
module line_ram
    import vga_pkg::*;
#(
    parameter int unsigned DEPTH = SCREEN_W,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic          wr_bank,
    input  logic [AW-1:0] wr_x,
    input  pixel_t        wr_data,
    input  logic          rd_en,
    input  logic          rd_active,
    input  logic          rd_bank,
    input  logic [AW-1:0] rd_x,
    output pixel_t        rd_data
);

    pixel_t mem [2][DEPTH];

    // NOTE: the array has no reset so it maps onto block RAM; stale contents
    // after reset are acceptable because every line is refilled before use.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_bank][wr_x] <= wr_data;
        end
    end

    // Output register doubles as the blanking gate, keeping RGB fully registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= rd_active ? mem[rd_bank][rd_x] : '0;
        end
    end

endmodule

// File: rtl/vga_scanout.sv
// VGA timing generator and line-fill consumer: requests one VRAM row per line,
// captures the arbiter's pixel writes and streams the previous line to the DAC.
module vga_scanout
    import vga_pkg::*;
#(
    parameter int unsigned LINE_W = SCREEN_W,
    parameter int unsigned HFP    = H_FP,
    parameter int unsigned HSW    = H_SYNC,
    parameter int unsigned HBP    = H_BP,
    parameter int unsigned LINES  = V_ACTIVE,
    parameter int unsigned VFP    = V_FP,
    parameter int unsigned VSW    = V_SYNC,
    parameter int unsigned VBP    = V_BP
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pix_en,
    input  logic        VGA_we,
    input  logic [9:0]  VGA_x,
    input  logic [23:0] VGA_data,
    output logic        VGA_re,
    output logic [8:0]  VGA_y,
    output logic [7:0]  VGA_R,
    output logic [7:0]  VGA_G,
    output logic [7:0]  VGA_B,
    output logic        VGA_HS,
    output logic        VGA_VS,
    output logic        VGA_BLANK_N,
    output logic        frame_start,
    output logic        fill_late
);

    localparam int unsigned HTOT = LINE_W + HFP + HSW + HBP;
    localparam int unsigned VTOT = LINES + VFP + VSW + VBP;
    localparam int unsigned AW   = $clog2(LINE_W);

    localparam logic [9:0] H_ACT  = 10'(LINE_W);
    localparam logic [9:0] H_LAST = 10'(HTOT - 1);
    localparam logic [9:0] HS_BEG = 10'(LINE_W + HFP);
    localparam logic [9:0] HS_END = 10'(LINE_W + HFP + HSW);
    localparam logic [9:0] V_ACT  = 10'(LINES);
    localparam logic [9:0] V_LAST = 10'(VTOT - 1);
    localparam logic [9:0] VS_BEG = 10'(LINES + VFP);
    localparam logic [9:0] VS_END = 10'(LINES + VFP + VSW);

    logic [9:0] h, v, vn;
    logic       active, wr_ok, ram_we;
    logic       disp_sel, fill_bank;
    pixel_t     rd_px;

    // NOTE: every signal gets its value on every path of this block, so no
    // latch can be inferred.
    always_comb begin
        vn     = (v == V_LAST) ? 10'd0 : v + 10'd1;
        active = (h < H_ACT) && (v < V_ACT);
        wr_ok  = VGA_we && (VGA_x < H_ACT);
        // Fill bank equal to display bank means the fill missed its swap.
        ram_we = wr_ok && (fill_bank != disp_sel);
    end

    line_ram #(
        .DEPTH (LINE_W),
        .AW    (AW)
    ) u_line_ram (
        .clk       (clk),
        .rst       (rst),
        .we        (ram_we),
        .wr_bank   (fill_bank),
        .wr_x      (VGA_x[AW-1:0]),
        .wr_data   (VGA_data),
        .rd_en     (pix_en),
        .rd_active (active),
        .rd_bank   (disp_sel),
        .rd_x      (h[AW-1:0]),
        .rd_data   (rd_px)
    );

    assign VGA_R = rd_px.r;
    assign VGA_G = rd_px.g;
    assign VGA_B = rd_px.b;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h           <= '0;
            v           <= '0;
            disp_sel    <= 1'b0;
            fill_bank   <= 1'b0;
            VGA_re      <= 1'b0;
            VGA_y       <= '0;
            VGA_HS      <= 1'b1;
            VGA_VS      <= 1'b1;
            VGA_BLANK_N <= 1'b0;
            frame_start <= 1'b0;
            fill_late   <= 1'b0;
        end else begin
            VGA_re      <= 1'b0;
            frame_start <= 1'b0;
            fill_late   <= wr_ok && (fill_bank == disp_sel);
            if (pix_en) begin
                frame_start <= (h == '0) && (v == '0);
                VGA_HS      <= !((h >= HS_BEG) && (h < HS_END));
                VGA_VS      <= !((v >= VS_BEG) && (v < VS_END));
                VGA_BLANK_N <= active;
                if (h == H_LAST) begin
                    h <= '0;
                    v <= vn;
                    if (vn < V_ACT) begin
                        disp_sel <= ~disp_sel;
                    end
                end else begin
                    h <= h + 10'd1;
                end
                // Request the next row as soon as this line's active pixels end.
                if ((h == H_ACT) && (vn < V_ACT)) begin
                    VGA_re    <= 1'b1;
                    VGA_y     <= vn[8:0];
                    fill_bank <= ~disp_sel;
                end
            end
        end
    end

endmodule

// File: tb/tb_vga_scanout.sv
// Directed bench: full-size timing for one line, plus a shrunken-timing
// instance that covers whole frames, line fills, late writes and mid-frame reset.
module tb_vga_scanout;

    localparam int SW    = 16;
    localparam int SHTOT = 24;
    localparam int SLINES = 6;
    localparam int SVTOT = 10;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        pix_en = 1'b0;
    logic        pix_en_f = 1'b0;
    logic        we = 1'b0;
    logic [9:0]  wx = '0;
    logic [23:0] wdata = '0;
    logic        we_f = 1'b0;
    logic [9:0]  wx_f = '0;
    logic [23:0] wdata_f = '0;

    logic       re, hs, vs, bn, fs, fl;
    logic [8:0] y;
    logic [7:0] r, g, b;
    logic       re_f, hs_f, vs_f, bn_f, fs_f, fl_f;
    logic [8:0] y_f;
    logic [7:0] r_f, g_f, b_f;

    int checks = 0;
    int failures = 0;
    int ph = 0, pv = 0, cur_h = 0, cur_v = 0, exp_y = 1;
    bit skip_line0 = 1'b1;

    always #5 clk = ~clk;

    vga_scanout #(
        .LINE_W(SW), .HFP(2), .HSW(4), .HBP(2),
        .LINES(SLINES), .VFP(1), .VSW(2), .VBP(1)
    ) dut (
        .clk(clk), .rst(rst), .pix_en(pix_en),
        .VGA_we(we), .VGA_x(wx), .VGA_data(wdata),
        .VGA_re(re), .VGA_y(y), .VGA_R(r), .VGA_G(g), .VGA_B(b),
        .VGA_HS(hs), .VGA_VS(vs), .VGA_BLANK_N(bn),
        .frame_start(fs), .fill_late(fl)
    );

    vga_scanout dut_full (
        .clk(clk), .rst(rst), .pix_en(pix_en_f),
        .VGA_we(we_f), .VGA_x(wx_f), .VGA_data(wdata_f),
        .VGA_re(re_f), .VGA_y(y_f), .VGA_R(r_f), .VGA_G(g_f), .VGA_B(b_f),
        .VGA_HS(hs_f), .VGA_VS(vs_f), .VGA_BLANK_N(bn_f),
        .frame_start(fs_f), .fill_late(fl_f)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h (h=%0d v=%0d)", tag, obs, exp, cur_h, cur_v);
        end
    endtask

    function automatic logic [23:0] pat(input int px, input int ln);
        return {8'(px), 8'hA0 + 8'(ln), 8'h55};
    endfunction

    task automatic wr(input logic [9:0] addr, input logic [23:0] d);
        we = 1'b1;
        wx = addr;
        wdata = d;
        @(posedge clk);
        #1;
        we = 1'b0;
    endtask

    task automatic pix();
        pix_en = 1'b1;
        @(posedge clk);
        #1;
        pix_en = 1'b0;
        cur_h = ph;
        cur_v = pv;
        if (ph == SHTOT - 1) begin
            ph = 0;
            pv = (pv == SVTOT - 1) ? 0 : pv + 1;
        end else begin
            ph++;
        end
    endtask

    task automatic check_reset_small(input string tag);
        check({tag, "_re"}, 32'(re), 32'd0);
        check({tag, "_y"}, 32'(y), 32'd0);
        check({tag, "_hs"}, 32'(hs), 32'd1);
        check({tag, "_vs"}, 32'(vs), 32'd1);
        check({tag, "_blank_n"}, 32'(bn), 32'd0);
        check({tag, "_rgb"}, 32'({r, g, b}), 32'd0);
        check({tag, "_frame_start"}, 32'(fs), 32'd0);
        check({tag, "_fill_late"}, 32'(fl), 32'd0);
    endtask

    // One pixel of the small instance: check every output, then service a request.
    task automatic pixel_step(input bit specials, input int f);
        bit re_exp, act;
        pix();
        act    = (cur_h < SW) && (cur_v < SLINES);
        re_exp = (cur_h == SW) && ((cur_v < SLINES - 1) || (cur_v == SVTOT - 1));
        check("hsync", 32'(hs), 32'(!(cur_h >= 18 && cur_h < 22)));
        check("vsync", 32'(vs), 32'(!(cur_v >= 7 && cur_v < 9)));
        check("blank_n", 32'(bn), 32'(act));
        check("frame_start", 32'(fs), 32'((cur_h == 0) && (cur_v == 0)));
        check("fill_late_idle", 32'(fl), 32'd0);
        check("vga_re", 32'(re), 32'(re_exp));
        if (!(skip_line0 && cur_v == 0)) begin
            check("rgb", 32'({r, g, b}), act ? 32'(pat(cur_h, cur_v)) : 32'd0);
        end
        if (re_exp) begin
            check("vga_y", 32'(y), 32'(exp_y));
            for (int i = 0; i < SW; i++) begin
                wr(10'(i), pat(i, exp_y));
            end
            if (specials && f == 1 && exp_y == 3) begin
                wr(10'd700, 24'h123456);
                check("x700_no_late", 32'(fl), 32'd0);
            end
            exp_y = (exp_y + 1) % SLINES;
        end
        if (specials && f == 1 && cur_h == SHTOT - 1 && cur_v == 3) begin
            wr(10'd5, 24'hDEAD01);
            check("late_write_pulse", 32'(fl), 32'd1);
        end
    endtask

    task automatic run_frames(input int nf, input bit specials);
        for (int f = 0; f < nf; f++) begin
            for (int k = 0; k < SHTOT * SVTOT; k++) begin
                pixel_step(specials, f);
            end
            skip_line0 = 1'b0;
        end
    endtask

    initial begin
        int fs_cnt, fs_at, hs_cnt, hs_first, hs_last, bn_cnt, bn_last, vs_cnt, re_cnt, re_at;

        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_reset_small("reset");
        check("full_reset_hs_vs", 32'({hs_f, vs_f}), 32'b11);
        check("full_reset_blank_re", 32'({bn_f, re_f, fs_f}), 32'd0);
        rst = 1'b0;

        // Nothing has been requested yet, so fill and display banks coincide.
        wr(10'd3, 24'h0F0F0F);
        check("early_write_late", 32'(fl), 32'd1);

        // Full-size timing, line 0 with a pixel strobe every clock.
        fs_cnt = 0; fs_at = -1; hs_cnt = 0; hs_first = -1; hs_last = -1;
        bn_cnt = 0; bn_last = -1; vs_cnt = 0; re_cnt = 0; re_at = -1;
        pix_en_f = 1'b1;
        for (int i = 0; i < 800; i++) begin
            @(posedge clk);
            #1;
            if (fs_f) begin fs_cnt++; fs_at = i; end
            if (!hs_f) begin
                hs_cnt++;
                if (hs_first < 0) hs_first = i;
                hs_last = i;
            end
            if (bn_f) begin bn_cnt++; bn_last = i; end
            if (!vs_f) vs_cnt++;
            if (re_f) begin re_cnt++; re_at = i; end
        end
        pix_en_f = 1'b0;
        check("full_frame_start_count", 32'(fs_cnt), 32'd1);
        check("full_frame_start_h", 32'(fs_at), 32'd0);
        check("full_hs_first", 32'(hs_first), 32'd656);
        check("full_hs_last", 32'(hs_last), 32'd751);
        check("full_hs_width", 32'(hs_cnt), 32'd96);
        check("full_blank_count", 32'(bn_cnt), 32'd640);
        check("full_blank_last", 32'(bn_last), 32'd639);
        check("full_vs_low", 32'(vs_cnt), 32'd0);
        check("full_re_count", 32'(re_cnt), 32'd1);
        check("full_re_h", 32'(re_at), 32'd640);
        check("full_re_y", 32'(y_f), 32'd1);

        // Shrunken timing: two whole frames including the x=700 and late-write cases.
        run_frames(2, 1'b1);

        // Stop mid-line in active video, then reset asynchronously.
        for (int k = 0; k <= 3 * SHTOT + 7; k++) begin
            pixel_step(1'b0, 2);
        end
        #2;
        rst = 1'b1;
        #1;
        check_reset_small("async_reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        ph = 0;
        pv = 0;
        exp_y = 1;
        skip_line0 = 1'b1;
        run_frames(1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
